// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nco_sweep_ctrl
//  Description : Steps the dsm_core NCO frequency word linearly from a start
//                value toward a stop value, holding each point for a dwell.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl #(
    parameter int ACC_WIDTH   = 32,
    parameter int DWELL_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   cfg_loop,
    input  logic                   cfg_down,
    input  logic [ACC_WIDTH-1:0]   cfg_start_step,
    input  logic [ACC_WIDTH-1:0]   cfg_stop_step,
    input  logic [ACC_WIDTH-1:0]   cfg_delta,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    output logic [ACC_WIDTH-1:0]   nco_step,
    output logic                   nco_step_enable,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   sweep_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DWELL = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [DWELL_WIDTH-1:0] C_DWELL_ONE = DWELL_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   C_CNT_ONE   = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic                   loop_q, loop_d;
    logic                   down_q, down_d;
    logic [ACC_WIDTH-1:0]   start_step_q, start_step_d;
    logic [ACC_WIDTH-1:0]   stop_step_q, stop_step_d;
    logic [ACC_WIDTH-1:0]   delta_q, delta_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [ACC_WIDTH-1:0]   nco_step_q, nco_step_d;
    logic                   enable_q, enable_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   sweep_count_q, sweep_count_d;

    // One extra bit exposes carry (up) or borrow (down) so wrap ends the sweep.
    logic [ACC_WIDTH:0]     next_sum;
    logic                   past_stop;
    logic                   sweep_end;

    always_comb begin
        if (down_q) begin
            next_sum  = {1'b0, nco_step_q} - {1'b0, delta_q};
            past_stop = next_sum[ACC_WIDTH-1:0] < stop_step_q;
        end else begin
            next_sum  = {1'b0, nco_step_q} + {1'b0, delta_q};
            past_stop = next_sum[ACC_WIDTH-1:0] > stop_step_q;
        end
        sweep_end = next_sum[ACC_WIDTH] || past_stop || (delta_q == '0);
    end

    always_comb begin
        state_d       = state_q;
        loop_d        = loop_q;
        down_d        = down_q;
        start_step_d  = start_step_q;
        stop_step_d   = stop_step_q;
        delta_d       = delta_q;
        dwell_d       = dwell_q;
        dwell_cnt_d   = dwell_cnt_q;
        nco_step_d    = nco_step_q;
        enable_d      = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        sweep_count_d = sweep_count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    loop_d        = cfg_loop;
                    down_d        = cfg_down;
                    start_step_d  = cfg_start_step;
                    stop_step_d   = cfg_stop_step;
                    delta_d       = cfg_delta;
                    dwell_d       = cfg_dwell;
                    sweep_count_d = '0;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                nco_step_d  = start_step_q;
                enable_d    = 1'b1;
                busy_d      = 1'b1;
                dwell_cnt_d = dwell_q;
                state_d     = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_cnt_q != '0) begin
                    dwell_cnt_d = dwell_cnt_q - C_DWELL_ONE;
                end else if (sweep_end) begin
                    sweep_count_d = sweep_count_q + C_CNT_ONE;
                    if (loop_q) begin
                        state_d = S_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                nco_step_d  = next_sum[ACC_WIDTH-1:0];
                enable_d    = 1'b1;
                dwell_cnt_d = dwell_q;
                state_d     = S_DWELL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a start in the same cycle.
        if (abort) begin
            state_d       = S_IDLE;
            loop_d        = loop_q;
            down_d        = down_q;
            start_step_d  = start_step_q;
            stop_step_d   = stop_step_q;
            delta_d       = delta_q;
            dwell_d       = dwell_q;
            nco_step_d    = nco_step_q;
            enable_d      = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            sweep_count_d = sweep_count_q;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q       <= S_IDLE;
            loop_q        <= 1'b0;
            down_q        <= 1'b0;
            start_step_q  <= '0;
            stop_step_q   <= '0;
            delta_q       <= '0;
            dwell_q       <= '0;
            dwell_cnt_q   <= '0;
            nco_step_q    <= '0;
            enable_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sweep_count_q <= '0;
        end else begin
            state_q       <= state_d;
            loop_q        <= loop_d;
            down_q        <= down_d;
            start_step_q  <= start_step_d;
            stop_step_q   <= stop_step_d;
            delta_q       <= delta_d;
            dwell_q       <= dwell_d;
            dwell_cnt_q   <= dwell_cnt_d;
            nco_step_q    <= nco_step_d;
            enable_q      <= enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sweep_count_q <= sweep_count_d;
        end
    end

    assign nco_step        = nco_step_q;
    assign nco_step_enable = enable_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign sweep_count     = sweep_count_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nco_sweep_ctrl
//  Description : Directed self-checking bench for nco_sweep_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cfg_loop = 1'b0;
    logic        cfg_down = 1'b0;
    logic [31:0] cfg_start_step = '0;
    logic [31:0] cfg_stop_step = '0;
    logic [31:0] cfg_delta = '0;
    logic [15:0] cfg_dwell = '0;
    logic [31:0] nco_step;
    logic        nco_step_enable;
    logic        busy;
    logic        done;
    logic [15:0] sweep_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] en_val [32];
    int          en_cyc [32];
    int          n_en, n_done, done_cyc, clash;

    nco_sweep_ctrl #(
        .ACC_WIDTH  (32),
        .DWELL_WIDTH(16),
        .CNT_WIDTH  (16)
    ) u_dut (
        .aclk           (aclk),
        .arst           (arst),
        .start          (start),
        .abort          (abort),
        .cfg_loop       (cfg_loop),
        .cfg_down       (cfg_down),
        .cfg_start_step (cfg_start_step),
        .cfg_stop_step  (cfg_stop_step),
        .cfg_delta      (cfg_delta),
        .cfg_dwell      (cfg_dwell),
        .nco_step       (nco_step),
        .nco_step_enable(nco_step_enable),
        .busy           (busy),
        .done           (done),
        .sweep_count    (sweep_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic configure(input logic lp, input logic dn, input logic [31:0] st,
                             input logic [31:0] sp, input logic [31:0] dl, input logic [15:0] dw);
        cfg_loop       = lp;
        cfg_down       = dn;
        cfg_start_step = st;
        cfg_stop_step  = sp;
        cfg_delta      = dl;
        cfg_dwell      = dw;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycle c counts edges after the start edge; enable/done events are logged by c.
    task automatic run_sweep(input int ncyc);
        n_en = 0; n_done = 0; done_cyc = -1; clash = 0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (nco_step_enable) begin
                if (n_en < 32) begin
                    en_val[n_en] = nco_step;
                    en_cyc[n_en] = c;
                end
                n_en++;
            end
            if (done) begin
                n_done++;
                done_cyc = c;
            end
            if (done && nco_step_enable) clash++;
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_step", nco_step, 32'h0);
        check("rst_en", {31'b0, nco_step_enable}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_cnt", {16'b0, sweep_count}, 32'h0);
        tick();
        arst = 1'b0;
        tick();

        // 1: up, single sweep
        configure(1'b0, 1'b0, 32'h100, 32'h130, 32'h10, 16'd3);
        pulse_start();
        run_sweep(24);
        check("t1_n_en", n_en, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_val%0d", i), en_val[i], 32'h100 + 32'h10 * i);
            check($sformatf("t1_cyc%0d", i), en_cyc[i], 1 + 5 * i);
        end
        check("t1_n_done", n_done, 1);
        check("t1_done_cyc", done_cyc, 20);
        check("t1_clash", clash, 0);
        check("t1_hold", nco_step, 32'h130);
        check("t1_busy", {31'b0, busy}, 32'h0);
        check("t1_cnt", {16'b0, sweep_count}, 32'd1);

        // 2: down, loop; stop value reached exactly is emitted
        configure(1'b1, 1'b1, 32'h40, 32'h10, 32'h18, 16'd0);
        pulse_start();
        run_sweep(20);
        check("t2_n_en", n_en, 10);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] exp_v;
            exp_v = (i % 3 == 0) ? 32'h40 : ((i % 3 == 1) ? 32'h28 : 32'h10);
            check($sformatf("t2_val%0d", i), en_val[i], exp_v);
            check($sformatf("t2_cyc%0d", i), en_cyc[i], 1 + 2 * i);
        end
        check("t2_n_done", n_done, 0);
        check("t2_cnt", {16'b0, sweep_count}, 32'd3);
        check("t2_busy", {31'b0, busy}, 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t2_abort_busy", {31'b0, busy}, 32'h0);
        tick();

        // 3: overflow of the up step ends the sweep after the first point
        configure(1'b0, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1);
        pulse_start();
        run_sweep(6);
        check("t3_n_en", n_en, 1);
        check("t3_val", en_val[0], 32'hFFFF_FFF0);
        check("t3_done_cyc", done_cyc, 3);
        check("t3_hold", nco_step, 32'hFFFF_FFF0);

        // 4: delta zero, long dwell
        configure(1'b0, 1'b0, 32'h55, 32'hFFFF, 32'h0, 16'd7);
        pulse_start();
        run_sweep(12);
        check("t4_n_en", n_en, 1);
        check("t4_val", en_val[0], 32'h55);
        check("t4_cyc", en_cyc[0], 1);
        check("t4_done_cyc", done_cyc, 9);
        check("t4_n_done", n_done, 1);

        // 5: abort with simultaneous start during dwell of third point
        configure(1'b0, 1'b0, 32'h200, 32'h300, 32'h40, 16'd5);
        pulse_start();
        run_sweep(17);
        check("t5_n_en", n_en, 3);
        check("t5_cyc2", en_cyc[2], 15);
        check("t5_val2", en_val[2], 32'h280);
        configure(1'b0, 1'b0, 32'h999, 32'hFFF, 32'h0, 16'd0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("t5_busy", {31'b0, busy}, 32'h0);
        check("t5_en", {31'b0, nco_step_enable}, 32'h0);
        run_sweep(10);
        check("t5_quiet_en", n_en, 0);
        check("t5_quiet_done", n_done, 0);
        check("t5_hold", nco_step, 32'h280);
        check("t5_cnt", {16'b0, sweep_count}, 32'd0);
        pulse_start();
        run_sweep(4);
        check("t5_re_n_en", n_en, 1);
        check("t5_re_val", en_val[0], 32'h999);
        check("t5_re_done", done_cyc, 2);
        check("t5_re_cnt", {16'b0, sweep_count}, 32'd1);

        // 6: asynchronous reset mid-sweep
        configure(1'b1, 1'b1, 32'h40, 32'h10, 32'h18, 16'd0);
        pulse_start();
        run_sweep(8);
        check("t6_pre_cnt", {16'b0, sweep_count}, 32'd1);
        check("t6_pre_step", nco_step, 32'h40);
        #2;
        arst = 1'b1;
        #1;
        check("t6_step", nco_step, 32'h0);
        check("t6_busy", {31'b0, busy}, 32'h0);
        check("t6_cnt", {16'b0, sweep_count}, 32'h0);
        check("t6_en", {31'b0, nco_step_enable}, 32'h0);
        tick();
        arst = 1'b0;
        run_sweep(4);
        check("t6_quiet_en", n_en, 0);
        check("t6_quiet_busy", {31'b0, busy}, 32'h0);
        configure(1'b0, 1'b0, 32'h700, 32'h700, 32'h1, 16'd2);
        pulse_start();
        check("t6_lat_en0", {31'b0, nco_step_enable}, 32'h0);
        run_sweep(6);
        check("t6_n_en", n_en, 1);
        check("t6_val", en_val[0], 32'h700);
        check("t6_cyc", en_cyc[0], 1);
        check("t6_done_cyc", done_cyc, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
